collision_checker: RTL and testbench
====================================

COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 SHALL have parameter TREX_BOX_COUNT, default 6, number of T-rex collision boxes.
REQ-002 SHALL have parameter OBS_BOX_COUNT, default obstacle_pkg::COLLISION_BOX_COUNT, number of obstacle collision boxes.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 check  in  1  single-cycle request to test the current frame.
REQ-007 obs_valid  in  1  front obstacle exists and is visible.
REQ-008 trex_x / obs_x  in  11 signed  sprite left edge.
REQ-009 trex_y / obs_y  in  10  sprite top edge.
REQ-010 trex_width, trex_height, obs_width, obs_height  in  10 each  outer sprite size.
REQ-011 trex_box[TREX_BOX_COUNT], obs_box[OBS_BOX_COUNT]  in  collision_pkg::collision_box_t  boxes relative to sprite origin (fields x, y, width, height).
REQ-012 clear  in  1  clears the sticky crash flag.
REQ-013 busy  out  1  check in progress.
REQ-014 done  out  1  single-cycle pulse at check completion.
REQ-015 crash  out  1  sticky collision flag, feeds the horizon's crash input.

Function
REQ-016 SHALL implement states IDLE, OUTER, INNER, DONE.
REQ-017 IDLE: on check=1, SHALL snapshot all position/size/box inputs and obs_valid, assert busy, go to OUTER.
REQ-018 check while busy SHALL be ignored; no queuing.
REQ-019 OUTER: if snapshot obs_valid=0, SHALL go to DONE with hit=0.
REQ-020 OUTER: SHALL compare outer boxes each inset by 1 px per side (x+1, y+1, w-2, h-2); no overlap -> DONE, hit=0; overlap -> INNER with i=j=0.
REQ-021 INNER: SHALL test one pair per cycle, trex_box[i] offset by (trex_x, trex_y) against obs_box[j] offset by (obs_x, obs_y).
REQ-022 Pair overlap -> hit=1, go to DONE immediately (early exit).
REQ-023 Index order: j increments first, wraps to 0 and i increments; after pair (TREX_BOX_COUNT-1, OBS_BOX_COUNT-1) with no hit -> DONE.
REQ-024 Overlap SHALL be strict: a.x < b.x+b.w and b.x < a.x+a.w and a.y < b.y+b.h and b.y < a.y+a.h.
REQ-025 Comparisons SHALL use 12-bit signed arithmetic; no wrap for negative obs_x or right-edge sums up to 1023+1023.
REQ-026 A box with width or height 0 SHALL never overlap; inset outer sizes below 2 SHALL be treated as 0.
REQ-027 DONE: SHALL pulse done for exactly one cycle, set crash if hit, deassert busy, return to IDLE.
REQ-028 Latency check->done: 2 cycles if obs_valid=0 or outer miss; at most 2+TREX_BOX_COUNT*OBS_BOX_COUNT cycles otherwise.
REQ-029 crash SHALL stay 1 until clear; if clear and a hit land in the same cycle, crash SHALL be 1.
REQ-030 clear SHALL NOT abort an in-progress check.

Reset
REQ-031 rst=0 SHALL force state IDLE, busy=0, done=0, crash=0, i=j=0 on the next clk edge, including mid-check; no done pulse follows.

Structure
REQ-032 collision_box_t, TREX_BOX_COUNT default and the overlap function SHALL live in collision_pkg.
REQ-033 One sub-module box_overlap (combinational, two boxes in, 1-bit out) SHALL be shared by OUTER and INNER.

Verification
REQ-034 obs_valid=0, check -> done at cycle 2, crash=0.
REQ-035 trex (50,100,44,47), obs (300,105,17,35) -> outer miss, done at cycle 2, crash=0.
REQ-036 outer overlap, only trex_box[5] vs obs_box[2] hits (6x3 boxes) -> done at cycle 2+5*3+3=20, crash=1.
REQ-037 outer overlap, all inner boxes disjoint -> done at cycle 20, crash=0; obs_x=-10 gives no spurious hit.
REQ-038 edges touching exactly (a.x+a.w == b.x) -> no hit; clear and hit same cycle -> crash=1.
REQ-039 rst=0 during INNER -> busy=0 next cycle, no done pulse, crash=0; new check runs normally.

Source files
------------

// File: rtl/collision_pkg.sv
// Types, constants and the overlap test shared by the collision checker.
//   collision_box_t : box relative to a sprite origin (x, y, width, height)
//   abs_box_t       : box in absolute 12-bit signed screen coordinates
//   state_t         : checker FSM states
//   boxes_overlap() : strict axis-aligned overlap, empty boxes never overlap
package collision_pkg;

  localparam int DEFAULT_TREX_BOX_COUNT = 6;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] width;
    logic [9:0] height;
  } collision_box_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [11:0] w;
    logic signed [11:0] h;
  } abs_box_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OUTER,
    ST_INNER,
    ST_DONE
  } state_t;

  // Edges that merely touch (a.x + a.w == b.x) do not count as overlap.
  function automatic logic boxes_overlap(input abs_box_t a, input abs_box_t b);
    logic non_empty;
    logic x_ov;
    logic y_ov;
    non_empty = (a.w != 12'sd0) && (a.h != 12'sd0) &&
                (b.w != 12'sd0) && (b.h != 12'sd0);
    x_ov = ($signed(a.x) < $signed(b.x + b.w)) && ($signed(b.x) < $signed(a.x + a.w));
    y_ov = ($signed(a.y) < $signed(b.y + b.h)) && ($signed(b.y) < $signed(a.y + a.h));
    return non_empty && x_ov && y_ov;
  endfunction

endpackage : collision_pkg

// File: rtl/obstacle_pkg.sv
// Obstacle-side shared constants.
// COLLISION_BOX_COUNT: number of collision boxes that describe one obstacle sprite.
package obstacle_pkg;

  localparam int COLLISION_BOX_COUNT = 3;

endpackage : obstacle_pkg

// File: rtl/collision_checker_box_overlap.sv
// Combinational overlap test between two absolute boxes.
//   a, b : boxes in absolute screen coordinates
//   hit  : 1 when the boxes strictly overlap
module box_overlap
  import collision_pkg::*;
(
  input  abs_box_t a,
  input  abs_box_t b,
  output logic     hit
);

  assign hit = boxes_overlap(a, b);

endmodule : box_overlap

// File: rtl/collision_checker.sv
// Sequential T-rex vs obstacle collision checker.
// A check request snapshots the current frame, tests the inset outer sprite
// boxes, then walks every (trex_box[i], obs_box[j]) pair one per cycle with
// early exit on the first hit. A hit sets the sticky crash flag.
//   clk, rst (sync, active-low), check : request, obs_valid : obstacle present
//   trex_*/obs_* : sprite position/size, trex_box/obs_box : relative boxes
//   clear : clears crash; busy/done/crash : status outputs
module collision_checker
  import collision_pkg::*;
#(
  parameter int TREX_BOX_COUNT = collision_pkg::DEFAULT_TREX_BOX_COUNT,
  parameter int OBS_BOX_COUNT  = obstacle_pkg::COLLISION_BOX_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check,
  input  logic                 obs_valid,
  input  logic signed [10:0]   trex_x,
  input  logic [9:0]           trex_y,
  input  logic [9:0]           trex_width,
  input  logic [9:0]           trex_height,
  input  logic signed [10:0]   obs_x,
  input  logic [9:0]           obs_y,
  input  logic [9:0]           obs_width,
  input  logic [9:0]           obs_height,
  input  collision_box_t       trex_box [TREX_BOX_COUNT],
  input  collision_box_t       obs_box  [OBS_BOX_COUNT],
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 crash
);

  localparam int IW = (TREX_BOX_COUNT > 1) ? $clog2(TREX_BOX_COUNT) : 1;
  localparam int JW = (OBS_BOX_COUNT > 1) ? $clog2(OBS_BOX_COUNT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(TREX_BOX_COUNT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OBS_BOX_COUNT - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic                  crash_q, crash_d;

  // Frame snapshot (data only, no reset needed)
  logic                  obs_valid_q, obs_valid_d;
  logic signed [10:0]    trex_x_q, trex_x_d, obs_x_q, obs_x_d;
  logic [9:0]            trex_y_q, trex_y_d, obs_y_q, obs_y_d;
  logic [9:0]            trex_w_q, trex_w_d, trex_h_q, trex_h_d;
  logic [9:0]            obs_w_q, obs_w_d, obs_h_q, obs_h_d;
  collision_box_t        trex_box_q [TREX_BOX_COUNT];
  collision_box_t        trex_box_d [TREX_BOX_COUNT];
  collision_box_t        obs_box_q  [OBS_BOX_COUNT];
  collision_box_t        obs_box_d  [OBS_BOX_COUNT];

  abs_box_t              cmp_a, cmp_b;
  logic                  cmp_hit;
  logic                  load;

  // Outer sizes shrink by 2 px; anything smaller than 2 becomes an empty box.
  function automatic logic signed [11:0] inset_size(input logic [9:0] s);
    return (s >= 10'd2) ? $signed({2'b00, s} - 12'd2) : 12'sd0;
  endfunction

  assign load = (state_q == ST_IDLE) && check;

  always_comb begin
    obs_valid_d = obs_valid_q;
    trex_x_d    = trex_x_q;
    trex_y_d    = trex_y_q;
    trex_w_d    = trex_w_q;
    trex_h_d    = trex_h_q;
    obs_x_d     = obs_x_q;
    obs_y_d     = obs_y_q;
    obs_w_d     = obs_w_q;
    obs_h_d     = obs_h_q;
    trex_box_d  = trex_box_q;
    obs_box_d   = obs_box_q;
    if (load) begin
      obs_valid_d = obs_valid;
      trex_x_d    = trex_x;
      trex_y_d    = trex_y;
      trex_w_d    = trex_width;
      trex_h_d    = trex_height;
      obs_x_d     = obs_x;
      obs_y_d     = obs_y;
      obs_w_d     = obs_width;
      obs_h_d     = obs_height;
      trex_box_d  = trex_box;
      obs_box_d   = obs_box;
    end
  end

  // One comparator serves both phases: outer sprites in OUTER, a box pair otherwise.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state_q == ST_OUTER) begin
      cmp_a.x = {trex_x_q[10], trex_x_q} + 12'sd1;
      cmp_a.y = $signed({2'b00, trex_y_q}) + 12'sd1;
      cmp_a.w = inset_size(trex_w_q);
      cmp_a.h = inset_size(trex_h_q);
      cmp_b.x = {obs_x_q[10], obs_x_q} + 12'sd1;
      cmp_b.y = $signed({2'b00, obs_y_q}) + 12'sd1;
      cmp_b.w = inset_size(obs_w_q);
      cmp_b.h = inset_size(obs_h_q);
    end else begin
      cmp_a.x = {trex_x_q[10], trex_x_q} + $signed({2'b00, trex_box_q[i_q].x});
      cmp_a.y = $signed({2'b00, trex_y_q}) + $signed({2'b00, trex_box_q[i_q].y});
      cmp_a.w = $signed({2'b00, trex_box_q[i_q].width});
      cmp_a.h = $signed({2'b00, trex_box_q[i_q].height});
      cmp_b.x = {obs_x_q[10], obs_x_q} + $signed({2'b00, obs_box_q[j_q].x});
      cmp_b.y = $signed({2'b00, obs_y_q}) + $signed({2'b00, obs_box_q[j_q].y});
      cmp_b.w = $signed({2'b00, obs_box_q[j_q].width});
      cmp_b.h = $signed({2'b00, obs_box_q[j_q].height});
    end
  end

  box_overlap u_box_overlap (
    .a   (cmp_a),
    .b   (cmp_b),
    .hit (cmp_hit)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    // A hit is recorded on the transition into DONE, so crash is already
    // visible while done pulses; a same-cycle clear loses to the hit.
    crash_d = crash_q & ~clear;
    unique case (state_q)
      ST_IDLE: begin
        if (check) state_d = ST_OUTER;
      end
      ST_OUTER: begin
        i_d = '0;
        j_d = '0;
        if (obs_valid_q && cmp_hit) state_d = ST_INNER;
        else                        state_d = ST_DONE;
      end
      ST_INNER: begin
        if (cmp_hit) begin
          state_d = ST_DONE;
          crash_d = 1'b1;
        end else if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) state_d = ST_DONE;
          else               i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        i_d     = '0;
        j_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      crash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      crash_q <= crash_d;
    end
  end

  always_ff @(posedge clk) begin
    obs_valid_q <= obs_valid_d;
    trex_x_q    <= trex_x_d;
    trex_y_q    <= trex_y_d;
    trex_w_q    <= trex_w_d;
    trex_h_q    <= trex_h_d;
    obs_x_q     <= obs_x_d;
    obs_y_q     <= obs_y_d;
    obs_w_q     <= obs_w_d;
    obs_h_q     <= obs_h_d;
    trex_box_q  <= trex_box_d;
    obs_box_q   <= obs_box_d;
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign crash = crash_q;

endmodule : collision_checker

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker: latency from check to done, crash
// flag behaviour, negative coordinates, touching edges, empty boxes, clear
// priority and mid-check reset.
module tb_collision_checker;
  import collision_pkg::*;

  localparam int TN = 6;
  localparam int ON = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                check;
  logic                obs_valid;
  logic signed [10:0]  trex_x, obs_x;
  logic [9:0]          trex_y, trex_width, trex_height;
  logic [9:0]          obs_y, obs_width, obs_height;
  collision_box_t      trex_box [TN];
  collision_box_t      obs_box  [ON];
  logic                clear;
  logic                busy, done, crash;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  collision_checker #(.TREX_BOX_COUNT(TN), .OBS_BOX_COUNT(ON)) dut (
    .clk(clk), .rst(rst), .check(check), .obs_valid(obs_valid),
    .trex_x(trex_x), .trex_y(trex_y), .trex_width(trex_width), .trex_height(trex_height),
    .obs_x(obs_x), .obs_y(obs_y), .obs_width(obs_width), .obs_height(obs_height),
    .trex_box(trex_box), .obs_box(obs_box), .clear(clear),
    .busy(busy), .done(done), .crash(crash)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic collision_box_t mk(input int x, input int y, input int w, input int h);
    collision_box_t b;
    b.x = 10'(x); b.y = 10'(y); b.width = 10'(w); b.height = 10'(h);
    return b;
  endfunction

  task automatic set_geom(input int tx, input int ty, input int tw, input int th,
                          input int ox, input int oy, input int ow, input int oh);
    trex_x = 11'(tx); trex_y = 10'(ty); trex_width = 10'(tw); trex_height = 10'(th);
    obs_x  = 11'(ox); obs_y  = 10'(oy); obs_width  = 10'(ow); obs_height  = 10'(oh);
  endtask

  // Raise check for 'hold' cycles, then count cycles until done (bounded).
  task automatic run_check(input int hold, output int l);
    check = 1'b1;
    l = 0;
    for (int k = 0; k < hold; k++) begin
      tick();
      l++;
    end
    check = 1'b0;
    while (!done && l < 60) begin
      tick();
      l++;
    end
  endtask

  task automatic do_case(input string tag, input int hold, input int exp_lat, input logic exp_crash);
    int l;
    run_check(hold, l);
    $display("check %s: latency %0d crash %0d", tag, l, crash);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_crash"}, crash, exp_crash);
    tick();
    chk({tag, "_done_single"}, done, 1'b0);
    chk({tag, "_busy_clear"}, busy, 1'b0);
  endtask

  // Geometry with outer overlap; only trex_box[5] vs obs_box[2] collide.
  task automatic geom_c();
    set_geom(50, 100, 44, 47, 80, 105, 17, 35);
    for (int k = 0; k < TN; k++) trex_box[k] = mk(0, 0, 2, 2);
    trex_box[5] = mk(30, 25, 5, 5);
    obs_box[0] = mk(10, 0, 2, 2);
    obs_box[1] = mk(10, 0, 2, 2);
    obs_box[2] = mk(0, 20, 5, 5);
  endtask

  // Obstacle partly off-screen to the left.
  task automatic geom_neg();
    set_geom(0, 100, 44, 47, -10, 105, 17, 35);
    for (int k = 0; k < TN; k++) trex_box[k] = mk(0, 5, 4, 4);
    for (int k = 0; k < ON; k++) obs_box[k] = mk(0, 0, 2, 2);
  endtask

  initial begin
    rst = 1'b0; check = 1'b0; clear = 1'b0; obs_valid = 1'b0;
    set_geom(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < TN; k++) trex_box[k] = mk(0, 0, 0, 0);
    for (int k = 0; k < ON; k++) obs_box[k] = mk(0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_crash", crash, 1'b0);
    rst = 1'b1;
    tick();

    // No obstacle: outer stage exits at once even though sprites overlap.
    geom_c();
    obs_valid = 1'b0;
    do_case("no_obstacle", 1, 2, 1'b0);

    obs_valid = 1'b1;
    set_geom(50, 100, 44, 47, 300, 105, 17, 35);
    do_case("outer_miss", 1, 2, 1'b0);

    geom_c();
    do_case("last_pair_hit", 1, 20, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_crash", crash, 1'b0);

    // check held high while busy must not restart the walk.
    geom_c();
    trex_box[5] = mk(0, 0, 2, 2);
    do_case("all_disjoint_held_check", 3, 20, 1'b0);

    geom_neg();
    do_case("neg_x_miss", 1, 20, 1'b0);

    geom_neg();
    obs_box[0] = mk(12, 0, 4, 4);
    do_case("neg_x_first_pair_hit", 1, 3, 1'b1);

    // Reset in the middle of INNER with crash already set.
    geom_c();
    check = 1'b1;
    tick();
    check = 1'b0;
    repeat (5) tick();
    chk("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_crash", crash, 1'b0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) pulses++;
    end
    chk("rst_no_done_pulse", pulses, 0);
    geom_c();
    do_case("after_rst_hit", 1, 20, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_crash_2", crash, 1'b0);

    // obs boxes start exactly where the trex boxes end.
    geom_neg();
    for (int k = 0; k < ON; k++) obs_box[k] = mk(14, 0, 4, 4);
    do_case("touching_edges", 1, 20, 1'b0);

    // Zero-width box placed inside a trex box.
    geom_neg();
    obs_box[0] = mk(12, 0, 0, 4);
    do_case("zero_width", 1, 20, 1'b0);

    // Clear held while the hit lands: hit wins.
    geom_neg();
    obs_box[0] = mk(12, 0, 4, 4);
    clear = 1'b1;
    run_check(1, lat);
    $display("check clear_and_hit: latency %0d crash %0d", lat, crash);
    chk("clear_and_hit_latency", lat, 3);
    chk("clear_and_hit_crash", crash, 1'b1);
    tick();
    chk("clear_after_hit", crash, 1'b0);
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_collision_checker
